pull_req_arbiter: RTL
=====================

// Module: pull_req_arbiter
// PURPOSE
//  - Shares one downstream req/ack (pull) responder, e.g. an entropy or key source, among NumReq
//    pull hosts.
//  - Round-robin grant. Exactly one downstream transaction is in flight at a time.
//  - The response data is registered and returned to the granted host with a one-cycle ack.
//  - Sits between the consumer IPs and the shared source. Each side obeys req/ack rules:
//    req held until ack, ack only while req, data known while ack.
// PARAMETERS
//  NumReq         4     number of upstream pull hosts (>=2)
//  DataWidth      32    payload width
//  TimeoutCycles  1024  downstream wait limit; used only with PULL_ARB_TIMEOUT_EN
// PORTS
//  clk        in   1               clock; single clock domain
//  rst_n      in   1               asynchronous, active-low reset
//  req_i      in   NumReq          per-host request; held high until its ack_o
//  ack_o      out  NumReq          per-host one-cycle ack, onehot0
//  data_o     out  DataWidth       response payload, shared by all hosts; valid while any ack_o
//  req_o      out  1               downstream request, registered
//  ack_i      in   1               downstream ack
//  data_i     in   DataWidth       downstream payload; sampled when ack_i is high
//  gnt_idx_o  out  $clog2(NumReq)  index of the current or last grant (debug/status)
//  err_o      out  1               sticky downstream-timeout flag
// BEHAVIOUR
//  - Reset values: ack_o=0, data_o=0, req_o=0, gnt_idx_o=0, err_o=0, state=IDLE, rr_ptr=0.
//  - FSM has 3 states:
//    IDLE: if any req_i, pick the first asserted index at or after rr_ptr (wrapping modulo NumReq).
//          Latch it into gnt_idx and go to REQ. req_o rises on the next edge.
//    REQ:  req_o=1. When ack_i=1: capture data_i into data_q and go to RESP; req_o drops on the
//          same edge. Otherwise stay in REQ.
//    RESP: ack_o[gnt_idx]=1 and data_o=data_q for exactly one cycle.
//          Then rr_ptr <= (gnt_idx+1)%NumReq and go to IDLE.
//  - Latency: ack_i at cycle N -> ack_o at N+1.
//    Minimum is 3 cycles per transaction: req_i seen -> req_o -> ack_i -> ack_o.
//  - A host still holding req_i in the cycle after its ack_o has issued a new request.
//    It is arbitrated normally, so rr_ptr gives other hosts precedence.
//  - Simultaneous requests are served strictly round-robin. No host waits more than NumReq-1
//    grants.
//  - data_o holds data_q between acks; data_q is not cleared. ack_o is never asserted for a host
//    whose req_i is low.
//  - Requests arriving in REQ or RESP are not granted until IDLE.
//  - req_i dropping while granted is a protocol violation. The transaction still completes and
//    ack_o is still pulsed.
//  - Reset mid-transaction: all state returns to reset values and req_o drops immediately
//    (asynchronous). No ack is replayed.
// CONFIGURATION
//  - PULL_ARB_TIMEOUT_EN defined: a cycle counter runs in REQ and clears on entry to REQ.
//    - When it reaches TimeoutCycles-1 without ack_i, err_o is set and stays set until reset.
//    - req_o stays high; the request is never dropped, and the FSM is otherwise unchanged.
//    - ack_i in the same cycle as the terminal count: ack wins and err_o is not set.
//  - PULL_ARB_TIMEOUT_EN undefined: no counter is built and err_o is tied to 0.
// STRUCTURE
//  - pull_arb_pkg holds:
//    - typedef enum logic [1:0] {StIdle, StReq, StResp} pull_arb_state_e
//    - function rr_pick(req, ptr) returning {found, idx}
//    - localparam TimeoutW = $clog2(TimeoutCycles)
//  - Sub-module pull_arb_rr_pick: purely combinational round-robin selector (NumReq, req, ptr ->
//    valid, idx). It is reusable by other arbiters.
//  - Top level holds the FSM, rr_ptr, data_q, gnt_idx and the optional timeout counter.
// TESTING
//  - Bench uses push_pull agents: NumReq pull hosts upstream and one pull device downstream.
//    The interface req/ack protocol assertions are enabled on every port.
//  - Single host: req_i=4'b0100, device acks after 2 cycles with data_i=32'hDEADBEEF.
//    -> ack_o=4'b0100 one cycle after ack_i, with data_o=32'hDEADBEEF. Other ack bits stay 0.
//  - All four hosts assert req_i together and hold each request until acked.
//    -> grants go 0,1,2,3, then 0 again, and each host gets exactly one ack per round.
//  - Host 1 holds req_i continuously while host 3 requests.
//    -> grants alternate 1,3,1,3. Host 1 is never granted twice in a row while host 3 waits.
//  - Assert rst_n low while in REQ with req_o=1.
//    -> req_o=0, ack_o=0 and err_o=0 immediately. After release, the first grant is to host 0.
//  - With PULL_ARB_TIMEOUT_EN and TimeoutCycles=16, the device withholds ack for 20 cycles.
//    -> err_o rises 16 cycles after req_o rose. After a late ack_i, ack_o pulses normally and
//       err_o stays 1.
//  - With PULL_ARB_TIMEOUT_EN and TimeoutCycles=16, ack_i arrives exactly on count 15.
//    -> err_o stays 0.

Source files
------------

// File: rtl/pull_arb_pkg.sv
// pull_arb_pkg: shared state type, round-robin helper and sizing constants
// for the pull request arbiter and its round-robin selector.
package pull_arb_pkg;

    // Arbiter FSM states: waiting for a host, waiting for the source, returning the ack.
    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StResp
    } pull_arb_state_e;

    // Widest request vector the round-robin helper handles.
    localparam int unsigned MaxReq  = 32;
    localparam int unsigned MaxIdxW = $clog2(MaxReq);

    // Default downstream wait limit and the counter width it needs.
    localparam int unsigned DefTimeoutCycles = 1024;
    localparam int unsigned TimeoutW         = $clog2(DefTimeoutCycles);

    // Result of a round-robin search: whether anyone requested, and who won.
    typedef struct packed {
        logic               found;
        logic [MaxIdxW-1:0] idx;
    } rr_pick_t;

    // Return the first asserted request at or after ptr, wrapping modulo num_req.
    // ptr must be below num_req and num_req must not exceed MaxReq.
    function automatic rr_pick_t rr_pick(input logic [MaxReq-1:0]  req,
                                         input logic [MaxIdxW-1:0] ptr,
                                         input int unsigned        num_req);
        rr_pick_t    res;
        int unsigned pos;
        res = '0;
        for (int unsigned i = 0; i < MaxReq; i++) begin
            pos = 32'(ptr) + i;
            if (pos >= num_req) begin
                pos = pos - num_req;
            end
            if ((i < num_req) && !res.found && req[pos[MaxIdxW-1:0]]) begin
                res.found = 1'b1;
                res.idx   = pos[MaxIdxW-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pull_arb_rr_pick.sv
// pull_arb_rr_pick: purely combinational round-robin selector. Given a request
// vector and a priority pointer it reports whether any request is set and the
// index of the first one at or after the pointer (wrapping). Usable by any arbiter.
module pull_arb_rr_pick
    import pull_arb_pkg::*;
#(
    parameter  int unsigned NumReq = 4,
    localparam int unsigned IdxW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req,
    input  logic [IdxW-1:0]   ptr,
    output logic              valid,
    output logic [IdxW-1:0]   idx
);

    logic [MaxReq-1:0]  req_ext;
    logic [MaxIdxW-1:0] ptr_ext;
    rr_pick_t           pick;
    logic               unused_pick_idx;

    // Widen request and pointer to the helper's fixed width, then narrow the winner back.
    always_comb begin
        req_ext             = '0;
        req_ext[NumReq-1:0] = req;
        ptr_ext             = '0;
        ptr_ext[IdxW-1:0]   = ptr;
        pick                = rr_pick(req_ext, ptr_ext, NumReq);
        valid               = pick.found;
        idx                 = pick.idx[IdxW-1:0];
    end

    // Upper index bits are always zero for NumReq below MaxReq.
    assign unused_pick_idx = ^pick.idx;

endmodule

// File: rtl/pull_req_arbiter.sv
// pull_req_arbiter: shares one downstream req/ack pull source among NumReq
// upstream pull hosts. Grants are round-robin, one downstream transaction is in
// flight at a time, and the captured response is returned to the granted host
// with a one-cycle ack.
// Optional feature macro PULL_ARB_TIMEOUT_EN: builds a downstream wait counter
// that sets a sticky err_o after TimeoutCycles cycles without ack_i. Without it
// err_o is constant 0 and no counter exists.
module pull_req_arbiter
    import pull_arb_pkg::*;
#(
    parameter  int unsigned NumReq        = 4,
    parameter  int unsigned DataWidth     = 32,
    parameter  int unsigned TimeoutCycles = DefTimeoutCycles,
    localparam int unsigned IdxW          = $clog2(NumReq)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NumReq-1:0]    req_i,
    output logic [NumReq-1:0]    ack_o,
    output logic [DataWidth-1:0] data_o,
    output logic                 req_o,
    input  logic                 ack_i,
    input  logic [DataWidth-1:0] data_i,
    output logic [IdxW-1:0]      gnt_idx_o,
    output logic                 err_o
);

    pull_arb_state_e      state;
    logic [IdxW-1:0]      rr_ptr;
    logic [IdxW-1:0]      gnt_idx;
    logic [DataWidth-1:0] data_q;
    logic                 req_q;
    logic [NumReq-1:0]    ack_q;

    logic                 pick_valid;
    logic [IdxW-1:0]      pick_idx;
    logic [NumReq-1:0]    gnt_onehot;
    logic [IdxW-1:0]      next_ptr;

    pull_arb_rr_pick #(
        .NumReq (NumReq)
    ) u_rr_pick (
        .req   (req_i),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Decode the current grant to an ack vector and compute the pointer just past it.
    always_comb begin
        gnt_onehot          = '0;
        gnt_onehot[gnt_idx] = 1'b1;
        if (gnt_idx == IdxW'(NumReq - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = gnt_idx + 1'b1;
        end
    end

    // Arbitration FSM: grant in IDLE, hold req_o until the source acks, then pulse the host ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= StIdle;
            rr_ptr  <= '0;
            gnt_idx <= '0;
            data_q  <= '0;
            req_q   <= 1'b0;
            ack_q   <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (pick_valid) begin
                        gnt_idx <= pick_idx;
                        req_q   <= 1'b1;
                        state   <= StReq;
                    end
                end
                StReq: begin
                    if (ack_i) begin
                        data_q <= data_i;
                        req_q  <= 1'b0;
                        ack_q  <= gnt_onehot;
                        state  <= StResp;
                    end
                end
                StResp: begin
                    ack_q  <= '0;
                    rr_ptr <= next_ptr;
                    state  <= StIdle;
                end
                default: begin
                    ack_q <= '0;
                    req_q <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

    assign ack_o     = ack_q;
    assign data_o    = data_q;
    assign req_o     = req_q;
    assign gnt_idx_o = gnt_idx;

`ifdef PULL_ARB_TIMEOUT_EN
    localparam int unsigned   CntW    = $clog2(TimeoutCycles);
    localparam logic [CntW-1:0] TermCnt = CntW'(TimeoutCycles - 1);

    logic [CntW-1:0] wait_cnt;
    logic            err_q;

    // Count cycles spent waiting in REQ; a terminal count without ack_i latches a sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == StIdle && pick_valid) begin
                wait_cnt <= '0;
            end else if (state == StReq && wait_cnt != TermCnt) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (state == StReq && !ack_i && wait_cnt == TermCnt) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_o = err_q;
`else
    // TimeoutCycles only matters when the counter is built.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TimeoutCycles != 0);
    assign err_o              = 1'b0;
`endif

endmodule
